// File: rtl/bt_air_pkg.sv
// Shared constants and types for the multi-device air-channel model.
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) in right-shifting form; delay-line entry layout.
package bt_air_pkg;

    localparam int          CH_W_DEF      = 7;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
    // Taps 16,14,13,11 land on bits 0,2,3,5 when the register shifts right.
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

    typedef struct packed {
        logic vld;
        logic dat;
        logic coll;
    } dly_ent_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAP_MASK), s[15:1]};
    endfunction

endpackage

// File: rtl/bt_air_dly.sv
// Per-receiver delay line, tap mux, LFSR bit-error injection and saturating counters.
// Latency 1 + i_delay cycles from i_raw; no backpressure, i_en=0 freezes state and zeroes outputs.
module bt_air_dly
    import bt_air_pkg::*;
#(
    parameter int          DLY_W = 4,
    parameter int          CNT_W = 16,
    parameter logic [15:0] SEED  = LFSR_SEED_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [2:0]       i_raw,
    input  logic [DLY_W-1:0] i_delay,
    input  logic [7:0]       i_thr,
    output logic             o_rxbit,
    output logic             o_rx_valid,
    output logic             o_rx_coll,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_coll_cnt
);

    localparam int DEPTH = 1 << DLY_W;

    dly_ent_t         r_line [0:DEPTH-2];
    dly_ent_t         w_taps [0:DEPTH-1];
    dly_ent_t         w_tap;
    logic [15:0]      r_lfsr;
    logic             w_flip;
    logic             r_rxbit, r_rx_valid, r_rx_coll;
    logic [CNT_W-1:0] r_err_cnt, r_coll_cnt;

    // Tap 0 is the upstream stage-1 register, so the line itself holds DEPTH-1 entries.
    always_comb begin
        w_taps[0] = dly_ent_t'(i_raw);
        for (int i = 1; i < DEPTH; i++) begin
            w_taps[i] = r_line[i-1];
        end
        w_tap  = w_taps[i_delay];
        w_flip = w_tap.vld && (r_lfsr[7:0] < i_thr);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                r_line[i] <= '0;
            end
            r_lfsr     <= SEED;
            r_rxbit    <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_coll  <= 1'b0;
        end else if (i_en) begin
            r_line[0] <= dly_ent_t'(i_raw);
            for (int i = 1; i < DEPTH - 1; i++) begin
                r_line[i] <= r_line[i-1];
            end
            r_lfsr     <= lfsr_next(r_lfsr);
            r_rxbit    <= w_tap.dat ^ w_flip;
            r_rx_valid <= w_tap.vld;
            r_rx_coll  <= w_tap.coll;
        end else begin
            r_rxbit    <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_coll  <= 1'b0;
        end
    end

    // A clear pulse wins over any increment landing on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_err_cnt  <= '0;
            r_coll_cnt <= '0;
        end else if (i_en) begin
            if (w_flip && !(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
            if (w_tap.coll && !(&r_coll_cnt)) begin
                r_coll_cnt <= r_coll_cnt + CNT_W'(1);
            end
        end
    end

    assign o_rxbit    = r_rxbit;
    assign o_rx_valid = r_rx_valid;
    assign o_rx_coll  = r_rx_coll;
    assign o_err_cnt  = r_err_cnt;
    assign o_coll_cnt = r_coll_cnt;

endmodule

// File: rtl/bt_air_channel.sv
// Air-interface emulator: routes N_DEV transmitters to receivers on matching hop channel fk.
// Latency 2 + cfg_delay[r] cycles; no backpressure, cfg_en=0 freezes the model.
module bt_air_channel
    import bt_air_pkg::*;
#(
    parameter int          N_DEV     = 4,
    parameter int          CH_W      = CH_W_DEF,
    parameter int          DLY_W     = 4,
    parameter int          CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic                   i_clk_6M,
    input  logic                   i_rst,
    input  logic                   i_cfg_en,
    input  logic                   i_clr_cnt_p,
    input  logic [N_DEV-1:0]       i_tx_en,
    input  logic [N_DEV-1:0]       i_txbit,
    input  logic [N_DEV*CH_W-1:0]  i_fk,
    input  logic [N_DEV*DLY_W-1:0] i_cfg_delay,
    input  logic [7:0]             i_cfg_ber_thr,
    output logic [N_DEV-1:0]       o_rxbit,
    output logic [N_DEV-1:0]       o_rx_valid,
    output logic [N_DEV-1:0]       o_rx_collision,
    output logic [N_DEV*CNT_W-1:0] o_err_cnt,
    output logic [N_DEV*CNT_W-1:0] o_coll_cnt
);

    logic [N_DEV-1:0]      w_any, w_multi, w_bit;
    logic [N_DEV-1:0][2:0] w_raw;
    logic [N_DEV-1:0][2:0] r_raw;

    // A transmitting device hears nothing (half duplex); w_bit is only meaningful with one source.
    always_comb begin
        w_any   = '0;
        w_multi = '0;
        w_bit   = '0;
        w_raw   = '0;
        for (int r = 0; r < N_DEV; r++) begin
            for (int t = 0; t < N_DEV; t++) begin
                if (t != r && i_tx_en[t] && !i_tx_en[r] &&
                    i_fk[t*CH_W +: CH_W] == i_fk[r*CH_W +: CH_W]) begin
                    w_multi[r] = w_multi[r] | w_any[r];
                    w_any[r]   = 1'b1;
                    w_bit[r]   = w_bit[r] | i_txbit[t];
                end
            end
            w_raw[r] = {w_any[r] & ~w_multi[r],
                        w_any[r] & ~w_multi[r] & w_bit[r],
                        w_multi[r]};
        end
    end

    always_ff @(posedge i_clk_6M) begin
        if (i_rst) begin
            r_raw <= '0;
        end else if (i_cfg_en) begin
            r_raw <= w_raw;
        end
    end

    for (genvar g = 0; g < N_DEV; g++) begin : g_rx
        bt_air_dly #(
            .DLY_W (DLY_W),
            .CNT_W (CNT_W),
            .SEED  (LFSR_SEED ^ 16'(g + 1))
        ) u_dly (
            .i_clk      (i_clk_6M),
            .i_rst      (i_rst),
            .i_en       (i_cfg_en),
            .i_clr      (i_clr_cnt_p),
            .i_raw      (r_raw[g]),
            .i_delay    (i_cfg_delay[g*DLY_W +: DLY_W]),
            .i_thr      (i_cfg_ber_thr),
            .o_rxbit    (o_rxbit[g]),
            .o_rx_valid (o_rx_valid[g]),
            .o_rx_coll  (o_rx_collision[g]),
            .o_err_cnt  (o_err_cnt[g*CNT_W +: CNT_W]),
            .o_coll_cnt (o_coll_cnt[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_bt_air_channel.sv
// Directed bench for bt_air_channel: a 4-device instance and a 2-device instance with 4-bit counters.
// Both share clock, reset, enable, clear and BER threshold.
module tb_bt_air_channel;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, clr;
    logic [7:0] thr;

    logic [3:0]  tx_en4, txbit4, rxbit4, vld4, coll4;
    logic [27:0] fk4;
    logic [15:0] dly4;
    logic [63:0] err4, cnt4;

    logic [1:0]  tx_en2, txbit2, rxbit2, vld2, coll2;
    logic [13:0] fk2;
    logic [7:0]  dly2, err2, cnt2;

    bt_air_channel u_dut4 (
        .i_clk_6M(clk), .i_rst(rst), .i_cfg_en(en), .i_clr_cnt_p(clr),
        .i_tx_en(tx_en4), .i_txbit(txbit4), .i_fk(fk4), .i_cfg_delay(dly4),
        .i_cfg_ber_thr(thr), .o_rxbit(rxbit4), .o_rx_valid(vld4),
        .o_rx_collision(coll4), .o_err_cnt(err4), .o_coll_cnt(cnt4)
    );

    bt_air_channel #(.N_DEV(2), .CNT_W(4)) u_dut2 (
        .i_clk_6M(clk), .i_rst(rst), .i_cfg_en(en), .i_clr_cnt_p(clr),
        .i_tx_en(tx_en2), .i_txbit(txbit2), .i_fk(fk2), .i_cfg_delay(dly2),
        .i_cfg_ber_thr(thr), .o_rxbit(rxbit2), .o_rx_valid(vld2),
        .o_rx_collision(coll2), .o_err_cnt(err2), .o_coll_cnt(cnt2)
    );

    int n_chk = 0;
    int n_err = 0;

    // Receiver 1 of both instances uses seed ACE1 ^ 2 and they share rst/en, so one model serves both.
    localparam logic [15:0] SEED1 = 16'hACE1 ^ 16'd2;
    logic [15:0] m, used_l;
    int          exp_err4;
    logic        hv [0:2047];
    logic        hb [0:2047];

    typedef struct {
        logic [1:0] tx_en;
        logic [1:0] txbit;
        logic [6:0] f0;
        logic [6:0] f1;
        logic [1:0] e_rx;
        logic [1:0] e_vld;
    } vec_t;
    vec_t tv [10];

    function automatic logic [15:0] ref_lfsr(input logic [15:0] l);
        logic fb;
        fb = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {fb, l[15:1]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // used_l is the LFSR value the DUT applies at this edge.
    task automatic tick();
        @(posedge clk);
        used_l = m;
        if (rst) m = SEED1;
        else if (en) m = ref_lfsr(m);
        #1;
    endtask

    // dev0 -> dev1 stream on fk 10 with receiver-1 delay d; enable dropped for cycles [off_lo, off_hi).
    task automatic stream(input int ncyc, input int d, input int off_lo, input int off_hi, input int tx_until);
        int   k, j;
        logic t_v, t_b, fl, e_v, e_b;
        fk4  = {7'd30, 7'd20, 7'd10, 7'd10};
        dly4 = {4'd0, 4'd0, 4'(d), 4'd0};
        tx_en4 = '0;
        rst = 1'b1; tick(); rst = 1'b0;
        exp_err4 = 0;
        k = 0;
        for (int c = 0; c < ncyc; c++) begin
            en        = !(c >= off_lo && c < off_hi);
            tx_en4[0] = (c < tx_until);
            txbit4[0] = 1'($urandom_range(0, 1));
            tick();
            if (en) begin
                j   = k - 1 - d;
                t_v = (j >= 0) ? hv[j] : 1'b0;
                t_b = (j >= 0) ? hb[j] : 1'b0;
                fl  = t_v && (used_l[7:0] < thr);
                if (fl) exp_err4++;
                hv[k] = tx_en4[0];
                hb[k] = tx_en4[0] & txbit4[0];
                k++;
                e_v = t_v;
                e_b = t_b ^ fl;
            end else begin
                e_v = 1'b0;
                e_b = 1'b0;
            end
            chk($sformatf("stream_vld c%0d", c), 64'(vld4[1]), 64'(e_v));
            chk($sformatf("stream_bit c%0d", c), 64'(rxbit4[1]), 64'(e_b));
        end
        en = 1'b1;
        tx_en4 = '0;
    endtask

    initial begin
        int lat, cnt, g;

        rst = 1'b1; en = 1'b1; clr = 1'b0; thr = 8'd0;
        tx_en4 = '0; txbit4 = '0; fk4 = '0; dly4 = '0;
        tx_en2 = '0; txbit2 = '0; fk2 = '0; dly2 = '0;
        m = '0;
        tick(); tick();
        rst = 1'b0;

        chk("reset_vld4", 64'(vld4), 64'd0);
        chk("reset_coll4", 64'(coll4), 64'd0);
        chk("reset_err4", err4, 64'd0);
        chk("reset_cnt4", cnt4, 64'd0);
        chk("reset_vld2", 64'(vld2), 64'd0);

        // Outputs after each tick reflect the previous row's stimulus.
        tv[0] = '{2'b01, 2'b01, 7'd23, 7'd23, 2'b00, 2'b00};
        tv[1] = '{2'b01, 2'b00, 7'd23, 7'd23, 2'b10, 2'b10};
        tv[2] = '{2'b01, 2'b01, 7'd23, 7'd23, 2'b00, 2'b10};
        tv[3] = '{2'b01, 2'b01, 7'd23, 7'd23, 2'b10, 2'b10};
        tv[4] = '{2'b01, 2'b01, 7'd23, 7'd24, 2'b10, 2'b10};
        tv[5] = '{2'b01, 2'b00, 7'd23, 7'd24, 2'b00, 2'b00};
        tv[6] = '{2'b11, 2'b11, 7'd23, 7'd23, 2'b00, 2'b00};
        tv[7] = '{2'b10, 2'b10, 7'd23, 7'd23, 2'b00, 2'b00};
        tv[8] = '{2'b00, 2'b00, 7'd23, 7'd23, 2'b01, 2'b01};
        tv[9] = '{2'b00, 2'b00, 7'd23, 7'd23, 2'b00, 2'b00};
        for (int i = 0; i < 10; i++) begin
            tx_en2 = tv[i].tx_en;
            txbit2 = tv[i].txbit;
            fk2    = {tv[i].f1, tv[i].f0};
            tick();
            chk($sformatf("vec%0d_rx", i), 64'(rxbit2), 64'(tv[i].e_rx));
            chk($sformatf("vec%0d_vld", i), 64'(vld2), 64'(tv[i].e_vld));
            chk($sformatf("vec%0d_coll", i), 64'(coll2), 64'd0);
        end
        chk("vec_err2", 64'(err2), 64'd0);

        // Collision: dev0 and dev2 on fk 5, dev1 listens there, dev3 alone on fk 9.
        rst = 1'b1; tick(); rst = 1'b0;
        fk4 = {7'd9, 7'd5, 7'd5, 7'd5};
        dly4 = '0;
        txbit4 = 4'b0101;
        for (int i = 0; i < 14; i++) begin
            tx_en4 = (i < 10) ? 4'b0101 : 4'b0000;
            tick();
            chk($sformatf("coll_c%0d", i), 64'(coll4), (i >= 1 && i <= 10) ? 64'h2 : 64'h0);
            chk($sformatf("coll_vld_c%0d", i), 64'(vld4), 64'd0);
        end
        chk("coll_cnt1", 64'(cnt4[31:16]), 64'd10);
        chk("coll_cnt_others", {cnt4[63:32], cnt4[15:0]}, 64'd0);

        // Latency sweep over every delay setting.
        fk4 = {7'd30, 7'd20, 7'd10, 7'd10};
        txbit4 = 4'b0001;
        for (int d = 0; d < 16; d++) begin
            dly4 = {4'd0, 4'd0, 4'(d), 4'd0};
            tx_en4 = '0;
            repeat (17) tick();
            tx_en4[0] = 1'b1;
            tick();
            lat = 1;
            tx_en4[0] = 1'b0;
            while (!vld4[1] && lat < 40) begin
                tick();
                lat++;
            end
            chk($sformatf("latency_d%0d", d), 64'(lat), 64'(2 + d));
            chk($sformatf("latency_bit_d%0d", d), 64'(rxbit4[1]), 64'd1);
            tick();
            chk($sformatf("pulse_width_d%0d", d), 64'(vld4[1]), 64'd0);
        end

        // Bit-error injection at thr=255 against the reference LFSR.
        thr = 8'd255;
        stream(1002, 0, -1, -1, 1000);
        chk("ber_err1", 64'(err4[31:16]), 64'(exp_err4));
        chk("ber_err0", 64'(err4[15:0]), 64'd0);

        // Clear pulse on the same edge as a flip.
        tx_en4[0] = 1'b1; txbit4[0] = 1'b1;
        tick();
        g = 0;
        while (m[7:0] == 8'hFF && g < 8) begin
            tick();
            g++;
        end
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_err1", 64'(err4[31:16]), 64'd0);
        chk("clr_flip_rx", 64'(rxbit4[1]), 64'd0);
        chk("clr_flip_vld", 64'(vld4[1]), 64'd1);
        tx_en4 = '0;

        // Enable dropped for 5 cycles with bits in flight (delay 3).
        thr = 8'd128;
        stream(34, 3, 12, 17, 26);
        chk("en_err1", 64'(err4[31:16]), 64'(exp_err4));

        // 4-bit error counter saturation on the 2-device instance.
        rst = 1'b1; tick(); rst = 1'b0;
        thr = 8'd255;
        tx_en2 = 2'b01; fk2 = {7'd23, 7'd23}; dly2 = '0;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            txbit2[0] = 1'($urandom_range(0, 1));
            tick();
            if (c >= 1 && used_l[7:0] < thr) cnt++;
        end
        chk("sat_err1", 64'(err2[7:4]), (cnt > 15) ? 64'd15 : 64'(cnt));
        chk("sat_err0", 64'(err2[3:0]), 64'd0);
        tx_en2 = '0;

        // Reset mid-stream discards in-flight bits.
        thr = 8'd255;
        stream(20, 5, -1, -1, 20);
        chk("pre_rst_err1", 64'(err4[31:16]), 64'(exp_err4));
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_vld", 64'(vld4), 64'd0);
        chk("rst_rx", 64'(rxbit4), 64'd0);
        chk("rst_coll", 64'(coll4), 64'd0);
        chk("rst_err", err4, 64'd0);
        chk("rst_cnt", cnt4, 64'd0);
        cnt = 0;
        repeat (8) begin
            tick();
            if (vld4 != 4'd0) cnt++;
        end
        chk("rst_flush_vld", 64'(cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bt_air_channel.md
Name: bt_air_channel

Overview:
- Parametrised air-interface emulator for multi-device link simulation and FPGA co-sim.
- Replaces the ad-hoc two-device "same fk, pass the bit, else x" channel model.
- Routes N_DEV transmitters to N_DEV receivers by hop channel (fk). Adds per-receiver propagation delay, LFSR-driven bit-error injection, collision detection and saturating statistics counters.
- Sits between the txbit/fk outputs and the rxbit inputs of the bt_top instances.

Parameters:
- N_DEV, 4, number of attached devices (2..8).
- CH_W, 7, hop-channel index width (fk).
- DLY_W, 4, delay select width; extra delay 0..2^DLY_W-1 cycles.
- CNT_W, 16, statistics counter width.
- LFSR_SEED, 16'hACE1, base seed; receiver r uses LFSR_SEED ^ (r+1).

Ports:
- clk_6M  in  1  6 MHz clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_en  in  1  channel enable; 0 freezes the model.
- clr_cnt_p  in  1  one-cycle pulse; clears all statistics counters.
- tx_en  in  N_DEV  device t is transmitting this cycle.
- txbit  in  N_DEV  transmit bit per device.
- fk  in  N_DEV*CH_W  hop channel per device; device d occupies slice d.
- cfg_delay  in  N_DEV*DLY_W  extra delay per receiver.
- cfg_ber_thr  in  8  error threshold; flip probability is thr/256.
- rxbit  out  N_DEV  received bit per device.
- rx_valid  out  N_DEV  rxbit carries a single clean source.
- rx_collision  out  N_DEV  two or more sources on the receiver's channel.
- err_cnt  out  N_DEV*CNT_W  injected-error count per receiver.
- coll_cnt  out  N_DEV*CNT_W  collision-cycle count per receiver.

Behaviour:
- Reset: all outputs 0, all delay lines 0, counters 0, LFSRs loaded with seeds.
- Source match, combinational, per receiver r:
  - M_r = {t != r : tx_en[t] && fk[t]==fk[r]}.
  - If tx_en[r]=1 (half duplex), M_r is treated as empty.
- Stage 1, registered:
  - |M_r|==1: raw_valid=1, raw_bit=txbit[t], raw_coll=0.
  - |M_r|==0: raw_valid=0, raw_bit=0, raw_coll=0.
  - |M_r|>=2: raw_valid=0, raw_bit=0, raw_coll=1.
- Stage 2, delay line:
  - {raw_valid, raw_bit, raw_coll} is shifted into a per-receiver 2^DLY_W-deep shift register every enabled cycle.
  - The output tap is selected by cfg_delay[r]; tap 0 is the stage-1 register itself.
- Stage 3, registered error injection:
  - LFSR_r is 16-bit Fibonacci, taps 16,14,13,11. It advances one step every enabled cycle.
  - flip = tap_valid && (LFSR_r[7:0] < cfg_ber_thr).
  - rxbit = tap_bit ^ flip; rx_valid = tap_valid; rx_collision = tap_coll.
  - cfg_ber_thr=0 never flips. cfg_ber_thr=255 flips 255/256 of valid bits.
- Latency: txbit to rxbit is 2 + cfg_delay[r] cycles.
- Invariant: rx_valid and rx_collision are never both 1.
- rxbit is 0 whenever rx_valid=0. The bench wrapper may map this to x.
- Counters, updated in the same cycle as stage 3:
  - err_cnt[r] increments on flip; coll_cnt[r] increments on rx_collision.
  - Both saturate at all-ones, no wrap.
  - clr_cnt_p has priority over a same-cycle increment; the result is 0.
- cfg_en=0:
  - Delay lines, LFSRs and counters hold their state.
  - Outputs are forced to rxbit=0, rx_valid=0, rx_collision=0 on the next edge.
  - When re-enabled, operation resumes from the frozen state.
- cfg_delay change mid-stream: the tap moves immediately. Bits may be repeated or skipped once; no invalid data is created.
- fk change mid-bit: takes effect in the cycle it is sampled. There is no hop settling model.
- rst mid-operation: all in-flight bits are discarded.

Decomposition:
- Package bt_air_pkg:
  - LFSR polynomial/tap constants, default seed, CH_W default.
  - Typedef for the delay-line entry {valid, bit, coll}.
- Sub-module bt_air_dly, instantiated N_DEV times:
  - Shift register, tap mux, LFSR, error injection and both counters.
- The top level holds the source-match logic and stage 1 only.

Test Plan:
- N_DEV=2, dev0 tx_en=1, fk0=fk1=7'd23, txbit pattern 1011, cfg_delay=0, thr=0 -> rx1 shows 1011 with rx_valid=1 starting 2 cycles later; rx0 rx_valid=0; err_cnt=0.
- Same stimulus with fk1=7'd24 -> rx1 rx_valid=0, rxbit=0 throughout.
- Devs 0 and 2 both tx on fk=5, dev1 listening on fk=5 for 10 cycles -> rx1 rx_collision=1 for exactly 10 cycles; coll_cnt[1]=10; rx_valid[1]=0.
- cfg_delay[1]=4'd9, single 1 pulse from dev0 -> rx1 pulse appears 11 cycles after the input; sweep 0..15 and check latency = 2+d.
- thr=255, 1000 valid bits -> err_cnt counts every flip and the counted flips match a reference LFSR model bit-exactly; then clr_cnt_p coincident with a flip -> err_cnt=0; with CNT_W=4 the counter stops at 15.
- cfg_en dropped for 5 cycles mid-stream, and separately rst asserted mid-stream:
  - cfg_en case: outputs go 0 within 1 cycle; counters and the LFSR sequence hold, and the bit stream resumes with no loss.
  - rst case: all outputs and counters are 0 on the next edge.
